// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule generator: loads a 16-word block, then emits W_t for
// rounds 0..63 from a sliding 16-word window, one word per round_en advance.
module sha256_msg_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        round_en,
    output logic [31:0] w_t,
    output logic        w_valid,
    output logic [5:0]  round_idx,
    output logic        done
);

    typedef enum logic {LOAD, RUN} state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0][31:0]  window;
    logic [3:0]         ld_cnt;
    logic               accept;
    logic               advance;
    logic               last_round;
    logic [31:0]        w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        accept     = (state == LOAD) && word_valid;
        advance    = (state == RUN) && round_en;
        last_round = advance && (round_idx == 6'd63);
        // Window slot 0 is W_{t}, so W_{t+16} draws on slots 14, 9, 1 and 0.
        w_new      = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        w_valid    = 1'b0;
        case (state)
            LOAD: begin
                word_ready = 1'b1;
                if (accept && (ld_cnt == 4'd15)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                w_valid = 1'b1;
                if (last_round) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window    <= '0;
            ld_cnt    <= '0;
            round_idx <= '0;
            w_t       <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_round;
            if (accept) begin
                window <= {word_in, window[15:1]};
                ld_cnt <= ld_cnt + 4'd1;
                // Slot 1 becomes slot 0 after this shift, i.e. W0 of the block.
                if (ld_cnt == 4'd15) begin
                    w_t <= window[1];
                end
            end else if (advance) begin
                if (last_round) begin
                    round_idx <= '0;
                end else begin
                    window    <= {w_new, window[15:1]};
                    round_idx <= round_idx + 6'd1;
                    w_t       <= window[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: known "abc" vectors plus randomized blocks checked
// against a plain-array SHA-256 schedule expansion.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        round_en;
    logic [31:0] w_t;
    logic        w_valid;
    logic [5:0]  round_idx;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];

    typedef struct {
        int          t;
        logic [31:0] w;
    } vec_t;
    vec_t abc_tab [8];

    sha256_msg_sched dut (
        .clk        (clk),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .round_en   (round_en),
        .w_t        (w_t),
        .w_valid    (w_valid),
        .round_idx  (round_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = msg[t];
            end else begin
                exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                         + exp_w[t-7]
                         + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                         + exp_w[t-16];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        build_model();
    endtask

    // Starts and ends at a falling edge. gapped inserts an idle cycle before each
    // word; noisy toggles round_en randomly, which LOAD must ignore.
    task automatic load_block(input int nwords, input bit gapped, input bit noisy);
        for (int i = 0; i < nwords; i++) begin
            if (gapped) begin
                word_valid = 1'b0;
                word_in    = $urandom;
                round_en   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            chk($sformatf("word_ready_w%0d", i), 32'(word_ready), 32'd1);
            word_valid = 1'b1;
            word_in    = msg[i];
            round_en   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            chk("done_low_load", 32'(done), 32'd0);
        end
        word_valid = 1'b0;
        round_en   = 1'b0;
    endtask

    // Advances rounds with round_en at pct percent; returns at the done cycle or,
    // when stop_at is reached, without driving a further round.
    task automatic run_block(input int pct, input bit noisy, input int stop_at);
        int t = 0;
        int cyc = 0;
        bit en;
        while (1) begin
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: got round %0d, required done", t);
                break;
            end
            chk("w_valid_run", 32'(w_valid), 32'd1);
            chk("round_idx", 32'(round_idx), 32'(t));
            chk($sformatf("w_t_round%0d", t), w_t, exp_w[t]);
            chk("done_low_run", 32'(done), 32'd0);
            got[t] = w_t;
            if (t == stop_at) break;
            en         = ($urandom_range(0, 99) < pct);
            round_en   = en;
            word_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            word_in    = $urandom;
            @(negedge clk);
            cyc++;
            if (en) begin
                if (t == 63) begin
                    round_en   = 1'b0;
                    word_valid = 1'b0;
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("w_valid_done", 32'(w_valid), 32'd0);
                    chk("round_idx_done", 32'(round_idx), 32'd0);
                    chk("word_ready_done", 32'(word_ready), 32'd1);
                    break;
                end
                t++;
            end
        end
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_word_ready"}, 32'(word_ready), 32'd1);
        chk({tag, "_w_valid"}, 32'(w_valid), 32'd0);
        chk({tag, "_round_idx"}, 32'(round_idx), 32'd0);
        chk({tag, "_w_t"}, w_t, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        word_valid = 1'b0;
        round_en   = 1'b0;
    endtask

    task automatic check_abc_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_w%0d", tag, abc_tab[i].t), got[abc_tab[i].t], abc_tab[i].w);
        end
    endtask

    initial begin
        abc_tab[0] = '{0,  32'h61626380};
        abc_tab[1] = '{1,  32'h00000000};
        abc_tab[2] = '{7,  32'h00000000};
        abc_tab[3] = '{14, 32'h00000000};
        abc_tab[4] = '{15, 32'h00000018};
        abc_tab[5] = '{16, 32'h61626380};
        abc_tab[6] = '{17, 32'h000F0000};
        abc_tab[7] = '{9,  32'h00000000};

        reset      = 1'b1;
        word_valid = 1'b0;
        round_en   = 1'b0;
        word_in    = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_word_ready", 32'(word_ready), 32'd1);
            chk("idle_w_valid", 32'(w_valid), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_round_idx", 32'(round_idx), 32'd0);
            chk("idle_w_t", w_t, 32'd0);
        end

        // "abc" block, back-to-back
        set_abc();
        load_block(16, 1'b0, 1'b0);
        run_block(100, 1'b0, -1);
        check_abc_table("abc_b2b");

        // Random block whose W0 is presented in the done cycle, noisy inputs
        set_random();
        load_block(16, 1'b0, 1'b1);
        run_block(50, 1'b1, -1);

        // "abc" again with gapped load and ~30% round_en
        set_abc();
        load_block(16, 1'b1, 1'b1);
        run_block(30, 1'b1, -1);
        check_abc_table("abc_gap");
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);

        // Reset after 9 words of a load
        set_random();
        load_block(9, 1'b0, 1'b0);
        reset_check("rst_load");
        set_random();
        load_block(16, 1'b0, 1'b0);
        run_block(100, 1'b0, 40);
        reset_check("rst_run");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_run_no_done", 32'(done), 32'd0);
            chk("rst_run_ready", 32'(word_ready), 32'd1);
        end

        // Fresh block after reset
        set_random();
        load_block(16, 1'b1, 1'b0);
        run_block(70, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
